// File: rtl/bsg_mem_3r1w_sync_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bsg_mem_3r1w_sync_arb_pkg: shared types for the 3r1w arbiter      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package bsg_mem_3r1w_sync_arb_pkg;

    localparam int num_ports_gp   = 3;
    localparam int owner_width_gp = 4;   // wide enough for 16 requesters

    typedef logic [1:0] port_id_t;

    typedef struct packed {
        logic                      v;
        logic [owner_width_gp-1:0] owner;
        logic                      byp;
    } inflight_t;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_mem_3r1w_sync_arb_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bsg_mem_3r1w_sync_arb_pick: rotate from rr, pick first 3 eligible |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module bsg_mem_3r1w_sync_arb_pick
    import bsg_mem_3r1w_sync_arb_pkg::*;
#(
    parameter int num_req_p   = 4,
    parameter int idx_width_p = 2
) (
    input  logic [num_req_p-1:0]                eligible,
    input  logic [idx_width_p-1:0]              rr,
    output logic [num_ports_gp-1:0]             port_v,
    output logic [num_ports_gp*idx_width_p-1:0] port_owner,
    output logic [idx_width_p-1:0]              last
);

    int cnt;
    int idx;

    always_comb begin
        port_v     = '0;
        port_owner = '0;
        last       = rr;
        cnt        = 0;
        idx        = 0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(rr) + k;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            if (eligible[idx_width_p'(idx)] && (cnt < num_ports_gp)) begin
                port_v[port_id_t'(cnt)] = 1'b1;
                port_owner[cnt*idx_width_p +: idx_width_p] = idx_width_p'(idx);
                last = idx_width_p'(idx);
                cnt  = cnt + 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_mem_3r1w_sync_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bsg_mem_3r1w_sync_arb: shares a 3r1w sync RAM among num_req_p     |
// | readers; BSG_MEM_3R1W_SYNC_ARB_BYPASS_EN forwards conflicting      |
// | reads from write data.                  Revision: 1.0             |
// +------------------------------------------------------------------+
module bsg_mem_3r1w_sync_arb
    import bsg_mem_3r1w_sync_arb_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int els_p         = 64,
    parameter int num_req_p     = 4,
    parameter int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic                              w_v_i,
    input  logic [addr_width_lp-1:0]          w_addr_i,
    input  logic [width_p-1:0]                w_data_i,

    input  logic [num_req_p-1:0]              r_v_i,
    input  logic [num_req_p*addr_width_lp-1:0] r_addr_i,
    output logic [num_req_p-1:0]              r_ready_o,
    output logic [num_req_p-1:0]              r_data_v_o,
    output logic [num_req_p*width_p-1:0]      r_data_o,

    output logic                              mem_w_v_o,
    output logic [addr_width_lp-1:0]          mem_w_addr_o,
    output logic [width_p-1:0]                mem_w_data_o,
    output logic [num_ports_gp-1:0]           mem_r_v_o,
    output logic [num_ports_gp*addr_width_lp-1:0] mem_r_addr_o,
    input  logic [num_ports_gp*width_p-1:0]   mem_r_data_i
);

    localparam int idx_width_lp = safe_clog2(num_req_p);

    logic [num_req_p-1:0]                 conflict;
    logic [num_req_p-1:0]                 eligible;
    logic [num_ports_gp-1:0]              port_v;
    logic [num_ports_gp-1:0]              port_byp;
    logic [num_ports_gp*idx_width_lp-1:0] port_owner;
    logic [idx_width_lp-1:0]              last_grant;
    logic [idx_width_lp-1:0]              rr_r;
    logic [idx_width_lp-1:0]              rr_next;
    logic [addr_width_lp-1:0]             port_addr [num_ports_gp];
    logic [width_p-1:0]                   resp_data [num_ports_gp];
    logic [idx_width_lp-1:0]              ret_owner;
    inflight_t                            fl_r [num_ports_gp];

    assign mem_w_v_o    = w_v_i;
    assign mem_w_addr_o = w_addr_i;
    assign mem_w_data_o = w_data_i;

    for (genvar i = 0; i < num_req_p; i++) begin : g_conflict
        assign conflict[i] = w_v_i & (r_addr_i[i*addr_width_lp +: addr_width_lp] == w_addr_i);
    end

    // Gating with reset keeps grants, RAM reads and the pointer quiet during reset.
`ifdef BSG_MEM_3R1W_SYNC_ARB_BYPASS_EN
    assign eligible = r_v_i & {num_req_p{~reset_i}};
`else
    assign eligible = r_v_i & ~conflict & {num_req_p{~reset_i}};
`endif

    bsg_mem_3r1w_sync_arb_pick #(
        .num_req_p   (num_req_p),
        .idx_width_p (idx_width_lp)
    ) u_pick (
        .eligible   (eligible),
        .rr         (rr_r),
        .port_v     (port_v),
        .port_owner (port_owner),
        .last       (last_grant)
    );

    for (genvar p = 0; p < num_ports_gp; p++) begin : g_port
        logic [idx_width_lp-1:0] owner;
        assign owner        = port_owner[p*idx_width_lp +: idx_width_lp];
        assign port_addr[p] = r_addr_i[owner*addr_width_lp +: addr_width_lp];
`ifdef BSG_MEM_3R1W_SYNC_ARB_BYPASS_EN
        assign port_byp[p]  = port_v[p] & conflict[owner];
`else
        assign port_byp[p]  = 1'b0;
`endif
        assign mem_r_v_o[p] = port_v[p] & ~port_byp[p];
        assign mem_r_addr_o[p*addr_width_lp +: addr_width_lp] =
            mem_r_v_o[p] ? port_addr[p] : '0;
    end

    always_comb begin
        r_ready_o = '0;
        for (int p = 0; p < num_ports_gp; p++) begin
            if (port_v[p]) begin
                r_ready_o[port_owner[p*idx_width_lp +: idx_width_lp]] = 1'b1;
            end
        end
    end

    assign rr_next = (last_grant == idx_width_lp'(num_req_p - 1)) ? '0 : last_grant + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_r <= '0;
            for (int p = 0; p < num_ports_gp; p++) begin
                fl_r[p] <= '0;
            end
        end else begin
            if (|port_v) begin
                rr_r <= rr_next;
            end
            for (int p = 0; p < num_ports_gp; p++) begin
                fl_r[p] <= '{v:     port_v[p],
                             owner: owner_width_gp'(port_owner[p*idx_width_lp +: idx_width_lp]),
                             byp:   port_byp[p]};
            end
        end
    end

`ifdef BSG_MEM_3R1W_SYNC_ARB_BYPASS_EN
    logic [width_p-1:0] bd_r [num_ports_gp];

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < num_ports_gp; p++) begin
            if (port_byp[p]) begin
                bd_r[p] <= w_data_i;
            end
        end
    end

    for (genvar p = 0; p < num_ports_gp; p++) begin : g_resp
        assign resp_data[p] = fl_r[p].byp ? bd_r[p] : mem_r_data_i[p*width_p +: width_p];
    end
`else
    logic unused_byp;

    for (genvar p = 0; p < num_ports_gp; p++) begin : g_resp
        assign resp_data[p] = mem_r_data_i[p*width_p +: width_p];
    end
    assign unused_byp = fl_r[0].byp ^ fl_r[1].byp ^ fl_r[2].byp;
`endif

    // Owners are distinct within a cycle, so slices never collide.
    always_comb begin
        r_data_v_o = '0;
        r_data_o   = '0;
        ret_owner  = '0;
        for (int p = 0; p < num_ports_gp; p++) begin
            ret_owner = idx_width_lp'(fl_r[p].owner);
            if (fl_r[p].v) begin
                r_data_v_o[ret_owner] = 1'b1;
                r_data_o[ret_owner*width_p +: width_p] = resp_data[p];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int p = 0; p < num_ports_gp; p++) begin
                assert (!port_v[p] || (int'(port_addr[p]) < els_p))
                    else $error("granted read address out of range");
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_mem_3r1w_sync_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bsg_mem_3r1w_sync_arb: scoreboard bench with RAM model         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_bsg_mem_3r1w_sync_arb;

    localparam int W   = 32;
    localparam int ELS = 64;
    localparam int N   = 4;
    localparam int AW  = 6;
`ifdef BSG_MEM_3R1W_SYNC_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_i;
    logic            w_v_i;
    logic [AW-1:0]   w_addr_i;
    logic [W-1:0]    w_data_i;
    logic [N-1:0]    r_v_i;
    logic [N*AW-1:0] r_addr_i;
    logic [N-1:0]    r_ready_o;
    logic [N-1:0]    r_data_v_o;
    logic [N*W-1:0]  r_data_o;
    logic            mem_w_v_o;
    logic [AW-1:0]   mem_w_addr_o;
    logic [W-1:0]    mem_w_data_o;
    logic [2:0]      mem_r_v_o;
    logic [3*AW-1:0] mem_r_addr_o;
    logic [3*W-1:0]  mem_r_data_i;

    always #5 clk = ~clk;

    bsg_mem_3r1w_sync_arb #(
        .width_p   (W),
        .els_p     (ELS),
        .num_req_p (N)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .w_v_i        (w_v_i),
        .w_addr_i     (w_addr_i),
        .w_data_i     (w_data_i),
        .r_v_i        (r_v_i),
        .r_addr_i     (r_addr_i),
        .r_ready_o    (r_ready_o),
        .r_data_v_o   (r_data_v_o),
        .r_data_o     (r_data_o),
        .mem_w_v_o    (mem_w_v_o),
        .mem_w_addr_o (mem_w_addr_o),
        .mem_w_data_o (mem_w_data_o),
        .mem_r_v_o    (mem_r_v_o),
        .mem_r_addr_o (mem_r_addr_o),
        .mem_r_data_i (mem_r_data_i)
    );

    logic [W-1:0] ram     [ELS];
    logic [W-1:0] ref_mem [ELS];

    // Synchronous-read RAM; reads see contents from before this edge's write.
    always @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (mem_r_v_o[p]) mem_r_data_i[p*W +: W] <= ram[mem_r_addr_o[p*AW +: AW]];
        end
        if (mem_w_v_o) ram[mem_w_addr_o] <= mem_w_data_o;
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } exp_t;

    exp_t sbq [N][$];
    int   cyc = 0;
    int   rr_m = 0;
    int   wait_c [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected grants from the rotating-priority rule, expected data from ref_mem.
    logic [N-1:0]  conf, elig, exp_rdy;
    int            owners[$];
    logic [AW-1:0] ra;
    exp_t          ne;
    always @(negedge clk) begin : model
        chk("w_pass", {31'd0, mem_w_v_o, mem_w_addr_o, mem_w_data_o},
                      {31'd0, w_v_i, w_addr_i, w_data_i});
        if (reset_i) begin
            for (int i = 0; i < N; i++) begin
                sbq[i].delete();
                wait_c[i] = 0;
            end
            rr_m = 0;
            chk("rst_ready", r_ready_o, 0);
            chk("rst_memrv", mem_r_v_o, 0);
            chk("rst_dv", r_data_v_o, 0);
            chk("rst_data", r_data_o[63:0], 0);
        end else begin
            owners.delete();
            exp_rdy = '0;
            for (int i = 0; i < N; i++) begin
                conf[i] = w_v_i && (r_addr_i[i*AW +: AW] == w_addr_i);
                elig[i] = r_v_i[i] && (BYP || !conf[i]);
            end
            for (int k = 0; k < N; k++) begin
                if (elig[(rr_m + k) % N] && owners.size() < 3) owners.push_back((rr_m + k) % N);
            end
            foreach (owners[j]) exp_rdy[owners[j]] = 1'b1;
            chk("grant", r_ready_o, exp_rdy);
            for (int p = 0; p < 3; p++) begin
                if (p < owners.size()) begin
                    ra = r_addr_i[owners[p]*AW +: AW];
                    chk("port_v", mem_r_v_o[p], !(BYP && conf[owners[p]]));
                    if (mem_r_v_o[p]) chk("port_addr", mem_r_addr_o[p*AW +: AW], ra);
                    ne.due  = cyc + 1;
                    ne.data = conf[owners[p]] ? w_data_i : ref_mem[ra];
                    sbq[owners[p]].push_back(ne);
                end else begin
                    chk("port_idle", {mem_r_v_o[p], mem_r_addr_o[p*AW +: AW]}, 0);
                end
                if (mem_r_v_o[p] && mem_w_v_o)
                    chk("ram_same_addr", mem_r_addr_o[p*AW +: AW] == mem_w_addr_o, 0);
            end
            if (owners.size() > 0) rr_m = (owners[owners.size()-1] + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (r_v_i[i] && !conf[i] && !r_ready_o[i]) begin
                    wait_c[i]++;
                    chk("wait_bound", wait_c[i] > 2, 0);
                end else begin
                    wait_c[i] = 0;
                end
            end
        end
        if (w_v_i) ref_mem[w_addr_i] = w_data_i;
    end

    exp_t me;
    logic want;
    always @(negedge clk) begin : monitor
        if (!reset_i) begin
            for (int i = 0; i < N; i++) begin
                want = (sbq[i].size() != 0) && (sbq[i][0].due <= cyc);
                chk("resp_valid", r_data_v_o[i], want);
                if (r_data_v_o[i] && sbq[i].size() != 0) begin
                    me = sbq[i].pop_front();
                    chk("resp_cycle", cyc, me.due);
                    chk("resp_data", r_data_o[i*W +: W], me.data);
                end else if (!r_data_v_o[i]) begin
                    chk("idle_slice", r_data_o[i*W +: W], 0);
                    if (want) void'(sbq[i].pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        r_addr_i[i*AW +: AW] = a;
    endtask

    logic [N-1:0]  pend, acc;
    logic [AW-1:0] paddr [N];

    initial begin
        for (int a = 0; a < ELS; a++) begin
            ram[a]     = '0;
            ref_mem[a] = '0;
        end
        reset_i = 1'b1; w_v_i = 1'b0; w_addr_i = '0; w_data_i = '0;
        r_v_i = '0; r_addr_i = '0;
        tick(); tick();
        reset_i = 1'b0;

        // All four requesting after reset: r0..r2 first, then r3 leads.
        r_v_i = 4'b1111;
        for (int i = 0; i < N; i++) set_rd(i, AW'(i + 1));
        #1 chk("t1_grant", r_ready_o, 4'b0111);
        tick();
        for (int i = 0; i < N; i++) set_rd(i, AW'(i + 5));
        #1 chk("t1_rr", r_ready_o, 4'b1011);
        chk("t1_dv", r_data_v_o, 4'b0111);
        tick();
        r_v_i = '0;
        tick();

        // Read of the address being written.
        w_v_i = 1'b1; w_addr_i = AW'(5); w_data_i = 32'hDEAD;
        r_v_i = 4'b0010; set_rd(1, AW'(5));
`ifdef BSG_MEM_3R1W_SYNC_ARB_BYPASS_EN
        #1 chk("t2_ready", r_ready_o, 4'b0010);
        chk("t2_memrv", mem_r_v_o, 3'b000);
        tick();
        w_v_i = 1'b0; r_v_i = '0;
        #1 chk("t2_dv", r_data_v_o, 4'b0010);
        chk("t2_data", r_data_o[W +: W], 32'hDEAD);
`else
        #1 chk("t2_stall", r_ready_o, 4'b0000);
        chk("t2_memrv", mem_r_v_o, 3'b000);
        tick();
        w_v_i = 1'b0;
        #1 chk("t2_ready", r_ready_o, 4'b0010);
        tick();
        r_v_i = '0;
        #1 chk("t2_dv", r_data_v_o, 4'b0010);
        chk("t2_data", r_data_o[W +: W], 32'hDEAD);
`endif
        tick();

        // Two requesters on the same address.
        w_v_i = 1'b1; w_addr_i = AW'(7); w_data_i = 32'h1234;
        tick();
        w_v_i = 1'b0;
        r_v_i = 4'b0101; set_rd(0, AW'(7)); set_rd(2, AW'(7));
        #1 chk("dup_ready", r_ready_o, 4'b0101);
        chk("dup_memrv", mem_r_v_o, 3'b011);
        tick();
        r_v_i = '0;
        #1 chk("dup_d0", r_data_o[0 +: W], 32'h1234);
        chk("dup_d2", r_data_o[2*W +: W], 32'h1234);
        tick();

        // Asynchronous reset while reads are in flight.
        r_v_i = 4'b1111;
        for (int i = 0; i < N; i++) set_rd(i, AW'(i + 9));
        tick();
        reset_i = 1'b1;
        #1 chk("arst_dv", r_data_v_o, 0);
        chk("arst_data", r_data_o[63:0], 0);
        chk("arst_ready", r_ready_o, 0);
        chk("arst_memrv", mem_r_v_o, 0);
        tick(); tick();
        reset_i = 1'b0;
        #1 chk("arst_rr0", r_ready_o, 4'b0111);
        tick();
        r_v_i = '0;
        tick(); tick();

        // Random traffic: a request holds its address until accepted.
        pend = '0; acc = '0;
        repeat (10000) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] || acc[i]) begin
                    pend[i]  = ($urandom_range(0, 99) < 70);
                    paddr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, ELS-1))
                                                           : AW'($urandom_range(0, 15));
                end
                set_rd(i, paddr[i]);
            end
            r_v_i    = pend;
            w_v_i    = ($urandom_range(0, 99) < 40);
            w_addr_i = AW'($urandom_range(0, 15));
            w_data_i = $urandom;
            #1 acc = r_v_i & r_ready_o;
            tick();
        end
        r_v_i = '0; w_v_i = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < N; i++) chk("drain", sbq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
